// File: rtl/cn_serial_minsum.sv
// cn_serial_minsum: serial offset-min-sum check node; collects ROW_DEG v2c messages, then emits ROW_DEG c2v messages.
module cn_serial_minsum #(
    parameter int MSG_WIDTH = 6,
    parameter int ROW_DEG = 6,
    parameter int OFFSET = 0,
    localparam int IDX_W = (ROW_DEG > 2) ? $clog2(ROW_DEG) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_v2c_vld,
    input  logic [MSG_WIDTH-1:0] i_v2c,
    output logic                 o_v2c_rdy,
    output logic                 o_c2v_vld,
    output logic [MSG_WIDTH-1:0] o_c2v,
    output logic [IDX_W-1:0]     o_c2v_idx,
    input  logic                 i_c2v_rdy,
    output logic                 o_parity,
    output logic                 o_par_vld
);
    localparam int MW = MSG_WIDTH - 1;
    localparam logic [MW-1:0] MAXM = '1;
    typedef enum logic {COLLECT, EMIT} state_t;
    state_t state;
    logic [IDX_W-1:0] cnt, idx1;
    logic [ROW_DEG-1:0] sgn;
    logic sp, s_in, in_xfer, out_xfer, last;
    logic [MW-1:0] min1, min2, mag_in, mag_sel, mag;
    logic [MSG_WIDTH-1:0] val;
    assign s_in = i_v2c[MW];
    assign mag_in = i_v2c[MW-1:0];
    assign in_xfer = i_v2c_vld & o_v2c_rdy;
    assign out_xfer = o_c2v_vld & i_c2v_rdy;
    assign last = cnt == IDX_W'(ROW_DEG - 1);
    // cnt is the input index k while collecting and the output index j while emitting
    assign mag_sel = (cnt == idx1) ? min2 : min1;
    assign mag = (mag_sel > MW'(OFFSET)) ? mag_sel - MW'(OFFSET) : '0;
    assign val = {1'b0, mag};
    assign o_c2v = !o_c2v_vld ? '0 : (sp ^ sgn[cnt]) ? -val : val;
    assign o_c2v_idx = o_c2v_vld ? cnt : '0;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= COLLECT;
            cnt <= '0;
            idx1 <= '0;
            sgn <= '0;
            sp <= 1'b0;
            min1 <= MAXM;
            min2 <= MAXM;
            o_v2c_rdy <= 1'b0;
            o_c2v_vld <= 1'b0;
            o_parity <= 1'b0;
            o_par_vld <= 1'b0;
        end else begin
            o_par_vld <= 1'b0;
            if (state == COLLECT) begin
                o_v2c_rdy <= !(in_xfer && last);
                if (in_xfer) begin
                    sgn[cnt] <= s_in;
                    sp <= sp ^ s_in;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (mag_in < min1) begin
                        min2 <= min1;
                        min1 <= mag_in;
                        idx1 <= cnt;
                    end else if (mag_in < min2) begin
                        min2 <= mag_in;
                    end
                    if (last) begin
                        state <= EMIT;
                        o_c2v_vld <= 1'b1;
                        o_parity <= sp ^ s_in;
                        o_par_vld <= 1'b1;
                    end
                end
            end else if (out_xfer) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    state <= COLLECT;
                    o_c2v_vld <= 1'b0;
                    o_v2c_rdy <= 1'b1;
                    idx1 <= '0;
                    sp <= 1'b0;
                    min1 <= MAXM;
                    min2 <= MAXM;
                end
            end
        end
    end
endmodule

// File: tb/tb_cn_serial_minsum.sv
// tb_cn_serial_minsum: directed vectors on two instances sharing stimulus, OFFSET=0 and OFFSET=2.
module tb_cn_serial_minsum;
    logic clk = 1'b0, rst_n = 1'b0, vld = 1'b0, c2v_rdy = 1'b1;
    logic [5:0] v2c = '0;
    logic rdy0, rdy2, cvld0, cvld2, par0, par2, pv0, pv2;
    logic [5:0] c0, c2;
    logic [2:0] ix0, ix2;
    int passed = 0, total = 0, pulses = 0;

    typedef struct {
        logic [0:5][5:0] m;
        logic par;
        logic [0:5][5:0] e0;
        logic [0:5][5:0] e2;
    } vec_t;
    vec_t tv[5];

    always #5 clk = ~clk;
    always @(negedge clk) if (pv0) pulses++;

    cn_serial_minsum #(.MSG_WIDTH(6), .ROW_DEG(6), .OFFSET(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_v2c_vld(vld), .i_v2c(v2c), .o_v2c_rdy(rdy0),
        .o_c2v_vld(cvld0), .o_c2v(c0), .o_c2v_idx(ix0), .i_c2v_rdy(c2v_rdy),
        .o_parity(par0), .o_par_vld(pv0));
    cn_serial_minsum #(.MSG_WIDTH(6), .ROW_DEG(6), .OFFSET(2)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_v2c_vld(vld), .i_v2c(v2c), .o_v2c_rdy(rdy2),
        .o_c2v_vld(cvld2), .o_c2v(c2), .o_c2v_idx(ix2), .i_c2v_rdy(c2v_rdy),
        .o_parity(par2), .o_par_vld(pv2));

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    endtask

    task automatic chk_reset();
        chk("rst_v2c_rdy", 32'(rdy0), 32'd0);
        chk("rst_c2v_vld", 32'(cvld0 | cvld2), 32'd0);
        chk("rst_c2v", 32'(c0), 32'd0);
        chk("rst_idx", 32'(ix0), 32'd0);
        chk("rst_parity", 32'(par0), 32'd0);
        chk("rst_par_vld", 32'(pv0), 32'd0);
    endtask

    task automatic put(input logic [5:0] m, input bit now);
        int n;
        n = 0;
        vld = 1'b1;
        v2c = m;
        while (!rdy0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("accept_timeout", 32'd0, 32'd1);
        if (now) chk("b2b_accept_delay", 32'(n), 32'd0);
        @(negedge clk);
    endtask

    task automatic send(input vec_t v, input bit keep, input bit now);
        for (int k = 0; k < 6; k++) put(v.m[k], now && k == 0);
        if (!keep) vld = 1'b0;
        chk("par_vld", 32'({pv0, pv2}), 32'h3);
        chk("parity", 32'(par0), 32'(v.par));
        chk("parity_off2", 32'(par2), 32'(v.par));
    endtask

    task automatic emit(input vec_t v, input int stall);
        logic [5:0] h0, h2;
        for (int j = 0; j < 6; j++) begin
            if (j == stall) begin
                c2v_rdy = 1'b0;
                h0 = c0;
                h2 = c2;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_c2v", 32'(c0), 32'(h0));
                    chk("stall_c2v_off2", 32'(c2), 32'(h2));
                    chk("stall_idx", 32'(ix0), 32'(j));
                    chk("stall_v2c_rdy", 32'(rdy0), 32'd0);
                end
                c2v_rdy = 1'b1;
            end
            chk("c2v_vld", 32'({cvld0, cvld2}), 32'h3);
            chk("c2v_idx", 32'(ix0), 32'(j));
            chk("c2v", 32'(c0), 32'(v.e0[j]));
            chk("c2v_off2", 32'(c2), 32'(v.e2[j]));
            if (j > 0) chk("par_vld_single", 32'(pv0), 32'd0);
            @(negedge clk);
        end
        chk("v2c_rdy_after_emit", 32'(rdy0), 32'd1);
        chk("c2v_vld_after_emit", 32'(cvld0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p;
        tv[0] = '{m: {6'h05, 6'h23, 6'h07, 6'h02, 6'h29, 6'h04}, par: 1'b0,
                  e0: {6'h02, 6'h3E, 6'h02, 6'h03, 6'h3E, 6'h02},
                  e2: {6'h00, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00}};
        tv[1] = '{m: {6'h21, 6'h06, 6'h01, 6'h08, 6'h09, 6'h07}, par: 1'b1,
                  e0: {6'h01, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F},
                  e2: {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}};
        tv[2] = '{m: {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F}, par: 1'b0,
                  e0: {6'h21, 6'h21, 6'h21, 6'h21, 6'h21, 6'h21},
                  e2: {6'h23, 6'h23, 6'h23, 6'h23, 6'h23, 6'h23}};
        tv[3] = '{m: {6'h20, 6'h04, 6'h06, 6'h03, 6'h05, 6'h07}, par: 1'b1,
                  e0: {6'h03, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00},
                  e2: {6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00}};
        tv[4] = '{m: {6'h0A, 6'h0C, 6'h2F, 6'h0B, 6'h2E, 6'h21}, par: 1'b1,
                  e0: {6'h3F, 6'h3F, 6'h01, 6'h3F, 6'h01, 6'h0A},
                  e2: {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08}};
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_release", 32'(rdy0), 32'd1);
        for (int i = 0; i < 5; i++) begin
            send(tv[i], 1'b0, 1'b0);
            emit(tv[i], -1);
        end
        send(tv[0], 1'b0, 1'b0);
        emit(tv[0], 2);
        for (int k = 0; k < 3; k++) put(tv[3].m[k], 1'b0);
        vld = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rdy_after_midreset", 32'(rdy0), 32'd1);
        p = pulses;
        send(tv[0], 1'b0, 1'b0);
        emit(tv[0], -1);
        chk("par_pulse_count", 32'(pulses), 32'(p + 1));
        send(tv[4], 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        p = pulses;
        repeat (4) begin
            @(negedge clk);
            chk("no_stale_c2v", 32'({cvld0, cvld2}), 32'd0);
        end
        chk("no_stale_par", 32'(pulses), 32'(p));
        send(tv[0], 1'b1, 1'b0);
        emit(tv[0], -1);
        send(tv[1], 1'b0, 1'b1);
        emit(tv[1], -1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
